sm_trace_buf: RTL
=================

# sm_trace_buf

Synthesizable commit-trace buffer for the schoolMIPS core: samples the CPU's retired `pc`/`instr` pair on every enabled CPU cycle into an on-chip ring buffer. Capture can be armed, gated by a PC trigger, and stopped after a programmable record count. Readout uses a valid/ready port. It sits beside `sm_cpu` inside `sm_top` and replaces simulation-only instruction logging with hardware that also works on the board.

## Interface
Parameters:
- `DEPTH`, 16, number of records; power of two, ≥ 2
- `CYC_W`, 16, width of the per-record cycle stamp (wraps)
- `STOP_CNT`, 200, records captured before automatic stop; 0 = unlimited

Ports:
- `clk` in 1, system clock; one clock, all logic on its rising edge
- `rst_n` in 1, reset; synchronous, active-low
- `cpu_en` in 1, CPU commit strobe; one retired instruction per cycle while high
- `pc` in 32, PC of the committing instruction
- `instr` in 32, committing instruction word
- `arm` in 1, single-cycle pulse; clears the buffer and starts a session
- `ring_mode` in 1, 1 = overwrite oldest when full, 0 = stop when full
- `trig_en` in 1, 1 = wait for a `pc == trig_pc` match before capturing
- `trig_pc` in 32, trigger address
- `rd_ready` in 1, consumer pops the head record
- `rd_valid` out 1, head record present (buffer not empty)
- `rd_pc` out 32, head record PC
- `rd_instr` out 32, head record instruction
- `rd_cyc` out CYC_W, head record cycle stamp
- `count` out $clog2(DEPTH)+1, records currently held
- `state` out 2, FSM state encoding
- `overflow` out 1, sticky; a record was overwritten
- `done` out 1, high in DONE

## Operation
- FSM states: IDLE=0, ARMED=1, CAPTURE=2, DONE=3.
- IDLE: no capture. `arm` → ARMED if `trig_en`, else CAPTURE.
- ARMED: on `cpu_en && pc==trig_pc` → CAPTURE. The triggering commit is itself captured.
- CAPTURE: each `cpu_en` writes {pc, instr, cyc} at the write pointer and increments `cap_cnt`.
  - → DONE when `cap_cnt` reaches `STOP_CNT` (STOP_CNT≠0). The STOP_CNT-th record is written.
  - → DONE when the buffer becomes full with `ring_mode`=0.
- DONE: no capture. Readout continues.
- `arm` in any state: clears pointers, `count`, `overflow`, `cap_cnt`, `cyc`, then applies the IDLE transition rule. A simultaneous commit is ignored.
- `cyc` counter: increments on every `cpu_en` in ARMED and CAPTURE. It wraps modulo 2^CYC_W. A record stores the `cyc` value before the increment.
- Readout is show-ahead: `rd_*` always reflect the head entry. A pop occurs on `rd_valid && rd_ready`. `rd_ready` while empty is ignored.
- Full, write, and pop in the same cycle: write succeeds, `count` is unchanged, no overflow.
- Full, write, no pop, `ring_mode`=1: overwrite the oldest entry, advance the read pointer, `count` stays DEPTH, set `overflow`.
- Pointers are $clog2(DEPTH) bits and wrap naturally.

## Timing
- Commit sampled at edge t → `rd_valid`/`count` reflect it after edge t (visible in cycle t+1). Write-to-read latency is 1 cycle.
- A pop at edge t → next head visible in cycle t+1.
- State transitions take effect at the same edge as the causing commit.
- `done` follows `state` combinationally.
- Reset values: state=IDLE, `count`=0, `rd_valid`=0, `overflow`=0, `done`=0, `cap_cnt`=0, `cyc`=0.
- `rd_pc`/`rd_instr`/`rd_cyc` are don't-care while `rd_valid`=0. Memory contents are not reset.
- Reset mid-capture aborts the session immediately and discards all records.

## Structure
- Package `sm_trace_pkg` holds:
  - `trace_state_t` enum (IDLE/ARMED/CAPTURE/DONE)
  - `trace_rec_t` packed struct {pc, instr, cyc}, parameterised by CYC_W through a package localparam default
- Sub-module `sm_trace_ram`: DEPTH×$bits(trace_rec_t) register array with one synchronous write port and one asynchronous read port.
- Pointers, FSM and counters live in `sm_trace_buf`.

## Test plan
1. **No trigger, stop mode.** DEPTH=4, STOP_CNT=0, `ring_mode`=0, `trig_en`=0. Arm, then commit pc 0x00,0x04,0x08,0x0C,0x10. Required: 4 records stored, DONE after the 4th, the 0x10 commit is not captured, `overflow`=0. Popping returns pc 0x00..0x0C with cyc 0..3.
2. **Ring mode.** DEPTH=4, `ring_mode`=1, 6 commits with pc 0x00..0x14. Required: `count`=4, `overflow`=1, pops return 0x08,0x0C,0x10,0x14.
3. **Trigger.** `trig_en`=1, `trig_pc`=0x20; commit pc 0x18,0x1C,0x20,0x24. Required: state ARMED until the 0x20 commit, then 2 records (0x20 with cyc 2, then 0x24).
4. **Stop count.** STOP_CNT=3, DEPTH=16, 5 commits. Required: 3 records, DONE after the 3rd commit, later commits ignored.
5. **Simultaneous write and pop at full.** DEPTH=4, `ring_mode`=1, buffer full, commit with `rd_ready`=1 in the same cycle. Required: the oldest record is popped, the new record is appended, `count`=4, `overflow`=0.
6. **Reset mid-capture, then re-arm.** Assert `rst_n`=0 for 1 cycle with `count`=3. Required: state=IDLE, `count`=0, `rd_valid`=0. A new `arm` starts with cyc 0.

Source files
------------

// File: rtl/sm_trace_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sm_trace_pkg : shared types for the schoolMIPS commit-trace buffer
// Rev 1.0
// ---------------------------------------------------------------------------
package sm_trace_pkg;

  localparam int TRACE_CYC_W = 16;
  localparam int TRACE_REC_W = 64 + TRACE_CYC_W;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } trace_state_t;

  // Field order matches the packed word stored in sm_trace_ram.
  typedef struct packed {
    logic [31:0]            pc;
    logic [31:0]            instr;
    logic [TRACE_CYC_W-1:0] cyc;
  } trace_rec_t;

endpackage
`default_nettype wire

// File: rtl/sm_trace_ram.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sm_trace_ram : DEPTH x W register array, sync write, async read
// Rev 1.0
// ---------------------------------------------------------------------------
module sm_trace_ram
  import sm_trace_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int W     = TRACE_REC_W
) (
  input  logic                     clk,
  input  logic                     i_wr_en,
  input  logic [$clog2(DEPTH)-1:0] i_wr_addr,
  input  logic [W-1:0]             i_wr_data,
  input  logic [$clog2(DEPTH)-1:0] i_rd_addr,
  output logic [W-1:0]             o_rd_data
);

  logic [W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule
`default_nettype wire

// File: rtl/sm_trace_buf.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sm_trace_buf : armable, PC-triggered commit-trace ring buffer with
//                valid/ready readout
// Rev 1.0
// ---------------------------------------------------------------------------
module sm_trace_buf
  import sm_trace_pkg::*;
#(
  parameter int DEPTH    = 16,
  parameter int CYC_W    = TRACE_CYC_W,
  parameter int STOP_CNT = 200
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cpu_en,
  input  logic [31:0]              pc,
  input  logic [31:0]              instr,
  input  logic                     arm,
  input  logic                     ring_mode,
  input  logic                     trig_en,
  input  logic [31:0]              trig_pc,
  input  logic                     rd_ready,
  output logic                     rd_valid,
  output logic [31:0]              rd_pc,
  output logic [31:0]              rd_instr,
  output logic [CYC_W-1:0]         rd_cyc,
  output logic [$clog2(DEPTH):0]   count,
  output logic [1:0]               state,
  output logic                     overflow,
  output logic                     done
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = AW + 1;
  localparam int REC_W = 64 + CYC_W;

  trace_state_t     r_state;
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             r_overflow;
  logic [31:0]      r_cap_cnt;
  logic [CYC_W-1:0] r_cyc;

  logic             w_active;
  logic             w_hit;
  logic             w_pop;
  logic             w_full;
  logic             w_wr;
  logic             w_ovw;
  logic             w_stop;
  logic [31:0]      w_cap_nxt;
  logic [CW-1:0]    w_count_nxt;
  logic [REC_W-1:0] w_rd_data;

  assign w_active  = (r_state == ST_ARMED) || (r_state == ST_CAPTURE);
  assign w_hit     = cpu_en && ((r_state == ST_CAPTURE) ||
                                ((r_state == ST_ARMED) && (pc == trig_pc)));
  assign w_pop     = (r_count != '0) && rd_ready;
  assign w_full    = (r_count == CW'(DEPTH));
  // A full stop-mode buffer only accepts a commit if a pop frees a slot.
  assign w_wr      = w_hit && !arm && !(w_full && !ring_mode && !w_pop);
  assign w_ovw     = w_wr && w_full && !w_pop;
  assign w_cap_nxt = r_cap_cnt + 32'd1;

  always_comb begin
    w_count_nxt = r_count;
    if (w_wr && !w_pop && !w_full) begin
      w_count_nxt = r_count + 1'b1;
    end else if (!w_wr && w_pop) begin
      w_count_nxt = r_count - 1'b1;
    end
  end

  assign w_stop = w_wr && (((STOP_CNT != 0) && (w_cap_nxt == 32'(STOP_CNT))) ||
                           (!ring_mode && (w_count_nxt == CW'(DEPTH))));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_cap_cnt  <= '0;
      r_cyc      <= '0;
    end else if (arm) begin
      r_state    <= trig_en ? ST_ARMED : ST_CAPTURE;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_cap_cnt  <= '0;
      r_cyc      <= '0;
    end else begin
      r_count <= w_count_nxt;
      if (w_wr) begin
        r_wr_ptr  <= r_wr_ptr + 1'b1;
        r_cap_cnt <= w_cap_nxt;
      end
      if (w_pop || w_ovw) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_ovw) begin
        r_overflow <= 1'b1;
      end
      if (cpu_en && w_active) begin
        r_cyc <= r_cyc + 1'b1;
      end
      if (w_stop || (w_hit && !w_wr)) begin
        r_state <= ST_DONE;
      end else if (w_hit && (r_state == ST_ARMED)) begin
        r_state <= ST_CAPTURE;
      end
    end
  end

  sm_trace_ram #(
    .DEPTH (DEPTH),
    .W     (REC_W)
  ) u_ram (
    .clk       (clk),
    .i_wr_en   (w_wr),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data ({pc, instr, r_cyc}),
    .i_rd_addr (r_rd_ptr),
    .o_rd_data (w_rd_data)
  );

  assign rd_valid = (r_count != '0);
  assign rd_pc    = w_rd_data[REC_W-1 -: 32];
  assign rd_instr = w_rd_data[REC_W-33 -: 32];
  assign rd_cyc   = w_rd_data[CYC_W-1:0];
  assign count    = r_count;
  assign state    = r_state;
  assign overflow = r_overflow;
  assign done     = (r_state == ST_DONE);

endmodule
`default_nettype wire
